// File: rtl/gcd_dispatch.sv
// gcd_dispatch: queues GCD jobs, starts each on the lowest idle engine, collects tagged completions.
// Latency: accept->ENG_START two edges; ENG_DONE rise->CMP_VALID two edges; IRQ registered with the push.
// Backpressure: SUB_READY low while submit FIFO full; a full completion FIFO keeps engines busy and pending.
// Ports: CLK/RESET (async, active-high)/CLKEN gate all state; SUB_* job submit handshake;
//        ENG_* per-engine start pulse, held opcode/ct, done level and cycle count in;
//        CMP_* completion handshake; ENG_BUSY/SUB_LEVEL/CMP_LEVEL status; IRQ_EN/IRQ_THRESH/IRQ interrupt.

// gcd_dispatch_fifo: small circular FIFO with registered occupancy and a combinational head.
// Latency: a push is visible at the head on the cycle after the edge that wrote it.
// Backpressure: none inside; the owner never pushes when full (unless also popping) nor pops when empty.
module gcd_dispatch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module gcd_dispatch #(
    parameter int NUM_ENG = 4,
    parameter int QDEPTH  = 8,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 3,
    parameter int CNT_W   = 12
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CLKEN,
    input  logic                     SUB_VALID,
    output logic                     SUB_READY,
    input  logic [TAG_W-1:0]         SUB_TAG,
    input  logic [OP_W-1:0]          SUB_OPCODE,
    input  logic                     SUB_CT,
    output logic [NUM_ENG-1:0]       ENG_START,
    output logic [NUM_ENG*OP_W-1:0]  ENG_OPCODE,
    output logic [NUM_ENG-1:0]       ENG_CT,
    input  logic [NUM_ENG-1:0]       ENG_DONE,
    input  logic [NUM_ENG*CNT_W-1:0] ENG_CYCLES,
    output logic                     CMP_VALID,
    input  logic                     CMP_READY,
    output logic [TAG_W-1:0]         CMP_TAG,
    output logic [2:0]               CMP_ENG,
    output logic [CNT_W-1:0]         CMP_CYCLES,
    output logic [NUM_ENG-1:0]       ENG_BUSY,
    output logic [$clog2(QDEPTH):0]  SUB_LEVEL,
    output logic [$clog2(QDEPTH):0]  CMP_LEVEL,
    input  logic                     IRQ_EN,
    input  logic [$clog2(QDEPTH):0]  IRQ_THRESH,
    output logic                     IRQ
);
    localparam int LW = $clog2(QDEPTH) + 1;
    localparam int SW = TAG_W + OP_W + 1;
    localparam int CW = TAG_W + 3 + CNT_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(QDEPTH);

    logic [SW-1:0]      sub_head;
    logic               sub_push, sub_pop, sub_empty;
    logic [CW-1:0]      cmp_head, cmp_rec;
    logic               cmp_push, cmp_pop, cmp_full;

    logic [NUM_ENG-1:0] busy, pending, done_r, start_r, ct_r;
    logic [NUM_ENG-1:0] done_pulse, dsp_oh, cpl_oh, dsp_go, cpl_clr;
    logic [OP_W-1:0]    op_r  [NUM_ENG];
    logic [TAG_W-1:0]   tag_r [NUM_ENG];
    logic [CNT_W-1:0]   cyc_r [NUM_ENG];

    logic [2:0]         cpl_idx;
    logic [TAG_W-1:0]   cpl_tag;
    logic [CNT_W-1:0]   cpl_cyc;
    logic [LW-1:0]      cmp_level_next, irq_thr;
    logic               irq_r;

    // Ready is forced low during reset so nothing is offered into a FIFO being cleared.
    assign SUB_READY = ~RESET & (SUB_LEVEL < FULL_LVL);
    assign sub_push  = CLKEN & SUB_VALID & SUB_READY;
    assign sub_empty = (SUB_LEVEL == '0);

    // Lowest-index idle engine and lowest-index pending engine; descending scan lets the lowest win.
    always_comb begin
        dsp_oh  = '0;
        cpl_oh  = '0;
        cpl_idx = '0;
        cpl_tag = '0;
        cpl_cyc = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                dsp_oh    = '0;
                dsp_oh[i] = 1'b1;
            end
            if (pending[i]) begin
                cpl_oh    = '0;
                cpl_oh[i] = 1'b1;
                cpl_idx   = 3'(i);
                cpl_tag   = tag_r[i];
                cpl_cyc   = cyc_r[i];
            end
        end
    end

    assign sub_pop    = CLKEN & ~sub_empty & (|dsp_oh);
    assign dsp_go     = dsp_oh & {NUM_ENG{sub_pop}};
    assign done_pulse = ENG_DONE & ~done_r & busy;

    assign cmp_full = (CMP_LEVEL == FULL_LVL);
    assign cmp_pop  = CLKEN & CMP_VALID & CMP_READY;
    // A full completion FIFO can still take a record when its head leaves in the same cycle.
    assign cmp_push = CLKEN & (|pending) & (~cmp_full | cmp_pop);
    assign cpl_clr  = cpl_oh & {NUM_ENG{cmp_push}};
    assign cmp_rec  = {cpl_tag, cpl_idx, cpl_cyc};

    assign cmp_level_next = CMP_LEVEL + LW'(cmp_push) - LW'(cmp_pop);
    assign irq_thr        = (IRQ_THRESH == '0) ? LW'(1) : IRQ_THRESH;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy    <= '0;
            pending <= '0;
            done_r  <= '0;
            start_r <= '0;
            ct_r    <= '0;
            irq_r   <= 1'b0;
            for (int i = 0; i < NUM_ENG; i++) begin
                op_r[i]  <= '0;
                tag_r[i] <= '0;
                cyc_r[i] <= '0;
            end
        end else if (CLKEN) begin
            done_r  <= ENG_DONE;
            start_r <= dsp_go;
            busy    <= (busy & ~cpl_clr) | dsp_go;
            pending <= (pending | done_pulse) & ~cpl_clr;
            irq_r   <= IRQ_EN & (cmp_level_next >= irq_thr);
            for (int i = 0; i < NUM_ENG; i++) begin
                if (done_pulse[i]) cyc_r[i] <= ENG_CYCLES[i*CNT_W +: CNT_W];
                if (dsp_go[i]) begin
                    tag_r[i] <= sub_head[SW-1 -: TAG_W];
                    op_r[i]  <= sub_head[1 +: OP_W];
                    ct_r[i]  <= sub_head[0];
                end
            end
        end
    end

    gcd_dispatch_fifo #(.W(SW), .DEPTH(QDEPTH)) u_sub_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (sub_push),
        .push_dat ({SUB_TAG, SUB_OPCODE, SUB_CT}),
        .pop      (sub_pop),
        .head_dat (sub_head),
        .level    (SUB_LEVEL)
    );

    gcd_dispatch_fifo #(.W(CW), .DEPTH(QDEPTH)) u_cmp_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (cmp_push),
        .push_dat (cmp_rec),
        .pop      (cmp_pop),
        .head_dat (cmp_head),
        .level    (CMP_LEVEL)
    );

    for (genvar g = 0; g < NUM_ENG; g++) begin : g_op
        assign ENG_OPCODE[g*OP_W +: OP_W] = op_r[g];
    end

    assign ENG_START = start_r;
    assign ENG_CT    = ct_r;
    assign ENG_BUSY  = busy;
    assign CMP_VALID = (CMP_LEVEL != '0);
    assign {CMP_TAG, CMP_ENG, CMP_CYCLES} = cmp_head;
    assign IRQ       = irq_r;
endmodule

// File: tb/tb_gcd_dispatch.sv
module tb_gcd_dispatch;
    localparam int NE = 4, QD = 8, TW = 4, OW = 3, CWD = 12, LW = 4;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              CLKEN = 1'b1;
    logic              SUB_VALID = 1'b0;
    logic              SUB_READY;
    logic [TW-1:0]     SUB_TAG = '0;
    logic [OW-1:0]     SUB_OPCODE = '0;
    logic              SUB_CT = 1'b0;
    logic [NE-1:0]     ENG_START;
    logic [NE*OW-1:0]  ENG_OPCODE;
    logic [NE-1:0]     ENG_CT;
    logic [NE-1:0]     ENG_DONE = '0;
    logic [NE*CWD-1:0] ENG_CYCLES = '0;
    logic              CMP_VALID;
    logic              CMP_READY = 1'b0;
    logic [TW-1:0]     CMP_TAG;
    logic [2:0]        CMP_ENG;
    logic [CWD-1:0]    CMP_CYCLES;
    logic [NE-1:0]     ENG_BUSY;
    logic [LW-1:0]     SUB_LEVEL;
    logic [LW-1:0]     CMP_LEVEL;
    logic              IRQ_EN = 1'b0;
    logic [LW-1:0]     IRQ_THRESH = '0;
    logic              IRQ;

    gcd_dispatch #(.NUM_ENG(NE), .QDEPTH(QD), .TAG_W(TW), .OP_W(OW), .CNT_W(CWD)) dut (
        .CLK(CLK), .RESET(RESET), .CLKEN(CLKEN),
        .SUB_VALID(SUB_VALID), .SUB_READY(SUB_READY), .SUB_TAG(SUB_TAG),
        .SUB_OPCODE(SUB_OPCODE), .SUB_CT(SUB_CT),
        .ENG_START(ENG_START), .ENG_OPCODE(ENG_OPCODE), .ENG_CT(ENG_CT),
        .ENG_DONE(ENG_DONE), .ENG_CYCLES(ENG_CYCLES),
        .CMP_VALID(CMP_VALID), .CMP_READY(CMP_READY), .CMP_TAG(CMP_TAG),
        .CMP_ENG(CMP_ENG), .CMP_CYCLES(CMP_CYCLES),
        .ENG_BUSY(ENG_BUSY), .SUB_LEVEL(SUB_LEVEL), .CMP_LEVEL(CMP_LEVEL),
        .IRQ_EN(IRQ_EN), .IRQ_THRESH(IRQ_THRESH), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [TW-1:0] tag; logic [OW-1:0] op; logic ct; } job_t;
    typedef struct { logic [TW-1:0] tag; int eng; logic [CWD-1:0] cyc; } rec_t;

    int n_cmp = 0;
    int n_bad = 0;
    job_t job_q[$];        // accepted, not yet started (dispatch is in submit order)
    rec_t rec_q[$];        // finished by an engine, not yet read from the completion port
    int accepted = 0, started = 0, popped = 0;
    int cnt [NE];
    logic [TW-1:0] run_tag [NE];
    bit auto_eng = 1'b0;
    int start_order[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural engines: a start launches a countdown in enabled cycles, then done rises and
    // stays high (cycle count held) until the engine is started again.
    task automatic model_step();
        job_t j;
        logic [CWD-1:0] cyc;
        logic [LW-1:0] thr;
        for (int e = 0; e < NE; e++) begin
            if (ENG_START[e]) begin
                check("start_has_job", 64'(job_q.size() != 0), 64'd1);
                if (job_q.size() != 0) begin
                    j = job_q.pop_front();
                    check("start_opcode", 64'(ENG_OPCODE[e*OW +: OW]), 64'(j.op));
                    check("start_ct", 64'(ENG_CT[e]), 64'(j.ct));
                    run_tag[e] = j.tag;
                    started++;
                end
                ENG_DONE[e] = 1'b0;
                cnt[e] = $urandom_range(1, 6);
            end else if (cnt[e] > 0) begin
                cnt[e]--;
                if (cnt[e] == 0) begin
                    cyc = CWD'($urandom);
                    ENG_CYCLES[e*CWD +: CWD] = cyc;
                    ENG_DONE[e] = 1'b1;
                    rec_q.push_back('{run_tag[e], e, cyc});
                end
            end
        end
        check("sub_level_model", 64'(SUB_LEVEL), 64'(accepted - started));
        thr = (IRQ_THRESH == 0) ? LW'(1) : IRQ_THRESH;
        check("irq_model", 64'(IRQ), 64'(IRQ_EN && (CMP_LEVEL >= thr)));
    endtask

    task automatic check_pop();
        int k;
        k = -1;
        foreach (rec_q[i]) if (k < 0 && rec_q[i].eng == int'(CMP_ENG)) k = i;
        check("cmp_known_engine", 64'(k >= 0), 64'd1);
        if (k >= 0) begin
            check("cmp_tag_model", 64'(CMP_TAG), 64'(rec_q[k].tag));
            check("cmp_cycles_model", 64'(CMP_CYCLES), 64'(rec_q[k].cyc));
            rec_q.delete(k);
            popped++;
        end
    endtask

    task automatic tick();
        logic en;
        en = CLKEN;
        @(posedge CLK); #1;
        if (auto_eng && en) model_step();
    endtask

    task automatic step(input bit v, input logic [TW-1:0] tag, input logic [OW-1:0] op,
                        input bit ct, input bit r, input bit en);
        CLKEN = en; SUB_VALID = v; SUB_TAG = tag; SUB_OPCODE = op; SUB_CT = ct; CMP_READY = r;
        if (v && SUB_READY && en) begin
            job_q.push_back('{tag, op, ct});
            accepted++;
        end
        if (auto_eng && r && en && CMP_VALID) check_pop();
        tick();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, r, 1'b1);
    endtask

    task automatic do_reset();
        RESET = 1'b1; CLKEN = 1'b1; SUB_VALID = 1'b0; CMP_READY = 1'b0;
        ENG_DONE = '0; ENG_CYCLES = '0; IRQ_EN = 1'b0; IRQ_THRESH = '0; auto_eng = 1'b0;
        job_q.delete(); rec_q.delete(); accepted = 0; started = 0; popped = 0;
        for (int e = 0; e < NE; e++) cnt[e] = 0;
        @(posedge CLK); #1; @(posedge CLK); #3;
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        @(posedge CLK); #1; @(posedge CLK); #1;
        check("rst_sub_ready", 64'(SUB_READY), 64'd0);
        check("rst_outputs", 64'({ENG_START, ENG_OPCODE, ENG_CT, ENG_BUSY}), 64'd0);
        check("rst_cmp", 64'({CMP_VALID, CMP_TAG, CMP_ENG, CMP_CYCLES}), 64'd0);
        check("rst_levels_irq", 64'({SUB_LEVEL, CMP_LEVEL, IRQ}), 64'd0);
        #3 RESET = 1'b0;
        @(posedge CLK); #1;
        check("ready_after_reset", 64'(SUB_READY), 64'd1);

        // ---- single job ----
        step(1'b1, 4'd5, 3'd2, 1'b1, 1'b0, 1'b1);
        check("single_queued", 64'({SUB_LEVEL, ENG_START}), 64'({4'd1, 4'b0000}));
        idle(1, 1'b0);
        check("single_start", 64'(ENG_START), 64'b0001);
        check("single_op_ct", 64'({ENG_OPCODE[2:0], ENG_CT[0], ENG_BUSY}), 64'({3'd2, 1'b1, 4'b0001}));
        idle(1, 1'b0);
        check("single_start_1cyc", 64'({ENG_START, ENG_OPCODE[2:0]}), 64'({4'b0000, 3'd2}));
        idle(17, 1'b0);
        ENG_CYCLES[11:0] = 12'h014; ENG_DONE[0] = 1'b1;
        idle(1, 1'b0);
        check("single_pending_only", 64'({CMP_VALID, ENG_BUSY}), 64'({1'b0, 4'b0001}));
        idle(1, 1'b0);
        check("single_cmp", 64'({CMP_VALID, CMP_TAG, CMP_ENG, CMP_CYCLES}),
              64'({1'b1, 4'd5, 3'd0, 12'h014}));
        check("single_busy_clear", 64'({ENG_BUSY, CMP_LEVEL}), 64'({4'b0000, 4'd1}));
        ENG_DONE = '0;
        idle(1, 1'b1);
        check("single_popped", 64'(CMP_VALID), 64'd0);

        // ---- fill: engines never finish ----
        do_reset();
        start_order.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, TW'(i), OW'(i), 1'b0, 1'b0, 1'b1);
            for (int e = 0; e < NE; e++) if (ENG_START[e]) start_order.push_back(e);
        end
        check("fill_accepted", 64'(accepted), 64'd12);
        check("fill_level_ready", 64'({SUB_LEVEL, SUB_READY}), 64'({4'd8, 1'b0}));
        check("fill_nstarts", 64'(start_order.size()), 64'd4);
        for (int i = 0; i < start_order.size(); i++) check("fill_start_order", 64'(start_order[i]), 64'(i));

        // ---- simultaneous done on engines 1 and 3 ----
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, TW'(10 + i), 3'd1, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);
        check("sim_all_busy", 64'(ENG_BUSY), 64'b1111);
        ENG_CYCLES[12 +: 12] = 12'h111; ENG_CYCLES[36 +: 12] = 12'h333; ENG_DONE = 4'b1010;
        idle(1, 1'b0);
        check("sim_not_yet", 64'(CMP_VALID), 64'd0);
        ENG_DONE = '0;
        idle(1, 1'b0);
        check("sim_first", 64'({CMP_VALID, CMP_ENG, CMP_TAG, CMP_CYCLES}), 64'({1'b1, 3'd1, 4'd11, 12'h111}));
        idle(1, 1'b1);
        check("sim_second", 64'({CMP_LEVEL, CMP_ENG, CMP_TAG, CMP_CYCLES}), 64'({4'd1, 3'd3, 4'd13, 12'h333}));
        idle(1, 1'b1);
        check("sim_drained", 64'({CMP_VALID, ENG_BUSY}), 64'({1'b0, 4'b0101}));

        // ---- IRQ threshold ----
        do_reset();
        IRQ_EN = 1'b1; IRQ_THRESH = 4'd3;
        for (int i = 1; i <= 3; i++) step(1'b1, TW'(i), 3'd0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        for (int e = 0; e < 3; e++) begin
            ENG_DONE = '0; ENG_DONE[e] = 1'b1;
            idle(1, 1'b0);
            ENG_DONE = '0;
            idle(1, 1'b0);
            check("irq_level", 64'(CMP_LEVEL), 64'(e + 1));
            check("irq_thresh3", 64'(IRQ), 64'(e == 2));
        end
        idle(1, 1'b1);
        check("irq_after_pop", 64'({CMP_LEVEL, IRQ}), 64'({4'd2, 1'b0}));
        idle(2, 1'b1);
        IRQ_THRESH = 4'd0;
        step(1'b1, 4'd4, 3'd0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        ENG_DONE[0] = 1'b1;
        idle(1, 1'b0);
        ENG_DONE = '0;
        check("irq_t0_before", 64'(IRQ), 64'd0);
        idle(1, 1'b0);
        check("irq_t0_first", 64'({CMP_LEVEL, IRQ}), 64'({4'd1, 1'b1}));
        IRQ_EN = 1'b0;
        idle(1, 1'b0);
        check("irq_disabled", 64'(IRQ), 64'd0);

        // ---- CLKEN gating, then reset mid-job ----
        do_reset();
        step(1'b1, 4'd7, 3'd3, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        check("gate_started", 64'(ENG_START), 64'b0001);
        ENG_DONE[0] = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b1, 4'd9, 3'd1, 1'b1, 1'b0, 1'b0);
        check("gate_start_held", 64'(ENG_START), 64'b0001);
        ENG_DONE = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 4'd9, 3'd1, 1'b1, 1'b1, 1'b0);
        check("gate_no_accept", 64'(SUB_LEVEL), 64'd0);
        idle(1, 1'b0);
        check("gate_start_drop", 64'(ENG_START), 64'b0000);
        idle(3, 1'b0);
        check("gate_no_edge", 64'({CMP_VALID, ENG_BUSY}), 64'({1'b0, 4'b0001}));
        #2 RESET = 1'b1;
        #1;
        check("midrst_clear", 64'({SUB_READY, ENG_BUSY, ENG_OPCODE, SUB_LEVEL, IRQ}), 64'd0);
        #2 RESET = 1'b0;
        @(posedge CLK); #1;
        ENG_DONE[0] = 1'b1;
        idle(3, 1'b0);
        ENG_DONE = '0;
        check("midrst_done_ignored", 64'({CMP_VALID, ENG_BUSY}), 64'd0);

        // ---- completion backpressure with behavioural engines ----
        do_reset();
        auto_eng = 1'b1;
        for (int i = 0; i < 50 && accepted < 9; i++)
            step(1'b1, TW'(accepted), OW'($urandom), 1'($urandom), 1'b0, 1'b1);
        idle(40, 1'b0);
        check("bp_cmp_full", 64'({CMP_LEVEL, SUB_LEVEL}), 64'({4'd8, 4'd0}));
        check("bp_one_busy", 64'($countones(ENG_BUSY)), 64'd1);
        idle(1, 1'b1);
        check("bp_refill", 64'({CMP_LEVEL, ENG_BUSY}), 64'({4'd8, 4'b0000}));
        idle(10, 1'b1);
        check("bp_all_read", 64'({CMP_LEVEL, 8'(popped)}), 64'({4'd0, 8'd9}));

        // ---- randomized traffic against the model ----
        do_reset();
        auto_eng = 1'b1;
        IRQ_EN = 1'b1;
        IRQ_THRESH = LW'($urandom_range(0, 8));
        for (int c = 0; c < 4000 && popped < 60; c++)
            step(accepted < 60 && $urandom_range(0, 9) < 7, TW'($urandom), OW'($urandom),
                 1'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 9);
        check("rand_all_done", 64'(popped), 64'd60);
        check("rand_queues_empty", 64'(job_q.size() + rec_q.size()), 64'd0);
        auto_eng = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
